freq_div_mon: RTL and testbench

Monitor that checks a divided clock produced by `freq_div`. It samples the divided clock in the source `clk` domain, measures the period and the high time of each cycle in `clk` cycles, and compares each result against the expected division ratio and high-cycle count. Sticky error and timeout flags feed the MBIST/test controller, and a pass/done indication is raised after a programmable number of periods has been checked.

---
 rtl/freq_div_mon.sv | 168 ++++++++++++++++
 tb/tb_freq_div_mon.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_mon.sv
// Checks a divided clock against its expected period and high time, measured in clk cycles.
// Sticky error/timeout flags and a done/pass result are reported after NUM_CHECK periods.
module freq_div_mon #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned DUTY_NUM  = 2,
    parameter int unsigned NUM_CHECK = 8,
    parameter int unsigned W         = 16,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_div_num,
    input  logic         start,
    output logic         busy,
    output logic         meas_valid,
    output logic [W-1:0] period_cnt,
    output logic [W-1:0] high_cnt,
    output logic         err_period,
    output logic         err_high,
    output logic         timeout,
    output logic         done,
    output logic         pass
);

    localparam int unsigned CHK_W = 8;
    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             s0_q, s1_q;
    logic [W-1:0]     per_q, per_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [W-1:0]     period_q, period_d;
    logic [W-1:0]     high_q, high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             err_period_q, err_period_d;
    logic             err_high_q, err_high_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             rise_c;
    logic [W-1:0]     per_inc_c;
    logic [W-1:0]     hi_inc_c;

    assign rise_c    = s1_q & ~s0_q;
    assign per_inc_c = (per_q == CNT_MAX) ? per_q : per_q + W'(1);
    assign hi_inc_c  = (s1_q && (hi_q != CNT_MAX)) ? hi_q + W'(1) : hi_q;

    // Next-state and output computation
    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        hi_d         = hi_q;
        chk_d        = chk_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        err_period_d = err_period_q;
        err_high_d   = err_high_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_ARM;
                    err_period_d = 1'b0;
                    err_high_d   = 1'b0;
                    timeout_d    = 1'b0;
                    chk_d        = '0;
                    per_d        = '0;
                    hi_d         = '0;
                end
            end
            S_ARM: begin
                // First edge only aligns the measurement window
                if (rise_c) begin
                    state_d = S_MEAS;
                    per_d   = W'(1);
                    hi_d    = W'(1);
                end else if (per_q >= W'(TIMEOUT)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    per_d = per_inc_c;
                end
            end
            S_MEAS: begin
                if (rise_c) begin
                    period_d     = per_q;
                    high_d       = hi_q;
                    meas_valid_d = 1'b1;
                    if (per_q != W'(CLK_DIV)) err_period_d = 1'b1;
                    if (hi_q != W'(DUTY_NUM)) err_high_d = 1'b1;
                    chk_d = chk_q + CHK_W'(1);
                    per_d = W'(1);
                    hi_d  = W'(1);
                    if ((chk_q + CHK_W'(1)) == CHK_W'(NUM_CHECK)) state_d = S_DONE;
                end else if (per_q >= W'(TIMEOUT)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    per_d = per_inc_c;
                    hi_d  = hi_inc_c;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ARM) || (state_d == S_MEAS);
        done_d = (state_d == S_DONE);
        pass_d = done_d & ~(err_period_d | err_high_d | timeout_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            per_q        <= '0;
            hi_q         <= '0;
            chk_q        <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            err_period_q <= 1'b0;
            err_high_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= clk_div_num;
            s0_q         <= s1_q;
            per_q        <= per_d;
            hi_q         <= hi_d;
            chk_q        <= chk_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            err_period_q <= err_period_d;
            err_high_q   <= err_high_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign busy       = busy_q;
    assign meas_valid = meas_valid_q;
    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign err_period = err_period_q;
    assign err_high   = err_high_q;
    assign timeout    = timeout_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_freq_div_mon.sv
// Scoreboard bench for freq_div_mon: directed divided-clock patterns with hand-computed captures.
module tb_freq_div_mon;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] per;
        logic [W-1:0] hi;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_div_num = 1'b0;
    logic         start = 1'b0;
    logic         busy, meas_valid, err_period, err_high, timeout, done, pass;
    logic [W-1:0] period_cnt, high_cnt;

    exp_t exp_q[$];
    bit   bitq[$];
    bit   idle_val = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n_meas = 0;

    freq_div_mon #(
        .CLK_DIV(4), .DUTY_NUM(2), .NUM_CHECK(8), .W(W), .TIMEOUT(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_div_num(clk_div_num), .start(start),
        .busy(busy), .meas_valid(meas_valid), .period_cnt(period_cnt), .high_cnt(high_cnt),
        .err_period(err_period), .err_high(err_high), .timeout(timeout),
        .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: pops one expected capture per meas_valid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && meas_valid) begin
                n_meas++;
                if (exp_q.size() == 0) begin
                    check("unexpected meas_valid", 32'(meas_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("period_cnt", 32'(period_cnt), 32'(e.per));
                    check("high_cnt", 32'(high_cnt), 32'(e.hi));
                end
            end
        end
    end

    // Pattern driver: one bit per clk, idle level once the pattern queue drains
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bitq.size() > 0) clk_div_num = bitq.pop_front();
            else clk_div_num = idle_val;
        end
    end

    task automatic push_bits(input logic [7:0] bits, input int n, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = n - 1; i >= 0; i--) bitq.push_back(bits[i]);
    endtask

    task automatic push_exp(input int per, input int hi, input int count);
        exp_t e;
        e.per = W'(per);
        e.hi  = W'(hi);
        for (int i = 0; i < count; i++) exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_meas(input int target);
        int cyc = 0;
        while (n_meas < target && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("meas_valid count reached", 32'(n_meas >= target), 1);
    endtask

    task automatic run_check(input string name, input int base, input int exp_meas,
                             input bit exp_mv, input bit exp_pass, input bit exp_ep,
                             input bit exp_eh, input bit exp_to, output int cyc);
        logic mv_at_done;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        mv_at_done = meas_valid;
        #1;
        check({name, " done reached"}, 32'(done), 1);
        if (done === 1'b1) begin
            check({name, " meas_valid with done"}, 32'(mv_at_done), 32'(exp_mv));
            check({name, " captures"}, 32'(n_meas - base), 32'(exp_meas));
            check({name, " scoreboard drained"}, 32'(exp_q.size()), 0);
            check({name, " busy"}, 32'(busy), 0);
            check({name, " pass"}, 32'(pass), 32'(exp_pass));
            check({name, " err_period"}, 32'(err_period), 32'(exp_ep));
            check({name, " err_high"}, 32'(err_high), 32'(exp_eh));
            check({name, " timeout"}, 32'(timeout), 32'(exp_to));
        end
    endtask

    task automatic cleanup();
        bitq.delete();
        idle_val = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " flags"},
              32'({busy, meas_valid, err_period, err_high, timeout, done, pass}), 0);
        check({name, " period_cnt"}, 32'(period_cnt), 0);
        check({name, " high_cnt"}, 32'(high_cnt), 0);
    endtask

    initial begin
        int base;
        int cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal 1100
        base = n_meas;
        pulse_start();
        check("busy after start", 32'(busy), 1);
        push_exp(4, 2, 8);
        push_bits(8'b1100, 4, 10);
        run_check("nominal", base, 8, 1, 1, 0, 0, 0, cyc);
        cleanup();

        // Wrong duty 1110
        base = n_meas;
        pulse_start();
        push_exp(4, 3, 8);
        push_bits(8'b1110, 4, 10);
        run_check("duty", base, 8, 1, 0, 0, 1, 0, cyc);
        cleanup();

        // Wrong period 11000
        base = n_meas;
        pulse_start();
        push_exp(5, 2, 8);
        push_bits(8'b11000, 5, 10);
        run_check("period", base, 8, 1, 0, 1, 0, 0, cyc);
        cleanup();

        // Rerun from DONE clears the failing result; start in MEAS is ignored
        base = n_meas;
        pulse_start();
        check("rerun done cleared", 32'(done), 0);
        check("rerun flags cleared", 32'({pass, err_period, err_high, timeout}), 0);
        check("rerun busy", 32'(busy), 1);
        push_exp(4, 2, 8);
        push_bits(8'b1100, 4, 10);
        wait_meas(base + 2);
        pulse_start();
        run_check("rerun", base, 8, 1, 1, 0, 0, 0, cyc);
        cleanup();

        // Glitch period 10 inserted after three nominal periods
        base = n_meas;
        pulse_start();
        push_exp(4, 2, 3);
        push_exp(2, 1, 1);
        push_exp(4, 2, 4);
        push_bits(8'b1100, 4, 3);
        push_bits(8'b10, 2, 1);
        push_bits(8'b1100, 4, 6);
        run_check("glitch", base, 8, 1, 0, 1, 1, 0, cyc);
        cleanup();

        // Stuck low: timeout from ARM
        base = n_meas;
        pulse_start();
        run_check("stuck0", base, 0, 0, 0, 0, 0, 1, cyc);
        check("stuck0 latency in range", 32'(cyc >= 995 && cyc <= 1010), 1);
        cleanup();

        // Stuck high: one edge arms, then timeout from MEAS
        base = n_meas;
        pulse_start();
        idle_val = 1'b1;
        run_check("stuck1", base, 0, 0, 0, 0, 0, 1, cyc);
        cleanup();
        repeat (4) @(posedge clk);

        // Reset mid-run after three captures
        base = n_meas;
        pulse_start();
        push_exp(4, 2, 8);
        push_bits(8'b1100, 4, 10);
        wait_meas(base + 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid-run reset");
        exp_q.delete();
        bitq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("no done during reset", 32'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        base = n_meas;
        pulse_start();
        push_exp(4, 2, 8);
        push_bits(8'b1100, 4, 10);
        run_check("after reset", base, 8, 1, 1, 0, 0, 0, cyc);
        cleanup();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
